// File: rtl/link_align_ctrl.sv
// link_align_ctrl: word-alignment and link-state controller for an 8b/10b
// receive path, clocked on the byte clock.
//
// Walks the deserializer word boundary with single-cycle bitslip pulses until
// clean commas appear, seeds the decoder running disparity, verifies framing,
// then holds the link up while the per-window error rate stays below a
// threshold.
//
// Ports:
//   byteclk      in   byte clock, all logic on posedge
//   rst_n        in   synchronous reset, active low
//   enable       in   0 forces IDLE and clears align_fail
//   word_valid   in   new word and flags valid this cycle
//   comma_det    in   word is a comma
//   comma_pos    in   comma polarity (1 = 1001111100, 0 = 0110000011)
//   code_err     in   decoder code error
//   disp_err     in   decoder disparity error
//   bitslip      out  one-cycle pulse, shift boundary by one bit
//   slip_pos     out  current boundary offset 0..9
//   disp_load    out  one-cycle pulse, load disp_val into decoder
//   disp_val     out  disparity value to load
//   link_up      out  registered, high while LOCKED
//   state        out  0 IDLE, 1 HUNT, 2 SLIP, 3 VERIFY, 4 LOCKED
//   align_fail   out  sticky: full 10-position sweep found no comma
//
// Optional feature (macro LINK_ALIGN_STATS_EN):
//   err_cnt      out  saturating count of errors while LOCKED
//   relock_cnt   out  saturating count of LOCKED -> HUNT drops

module link_align_ctrl #(
    parameter int unsigned HUNT_TIMEOUT  = 32,
    parameter int unsigned SLIP_SETTLE   = 3,
    parameter int unsigned VERIFY_WORDS  = 16,
    parameter int unsigned VERIFY_COMMAS = 2,
    parameter int unsigned ERR_WINDOW    = 64,
    parameter int unsigned ERR_THRESH    = 4
) (
    input  logic        byteclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        word_valid,
    input  logic        comma_det,
    input  logic        comma_pos,
    input  logic        code_err,
    input  logic        disp_err,
    output logic        bitslip,
    output logic [3:0]  slip_pos,
    output logic        disp_load,
    output logic        disp_val,
    output logic        link_up,
    output logic [2:0]  state,
    output logic        align_fail
`ifdef LINK_ALIGN_STATS_EN
    ,
    output logic [15:0] err_cnt,
    output logic [7:0]  relock_cnt
`endif
);

    localparam int unsigned HW = $clog2(HUNT_TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SLIP_SETTLE + 1);
    localparam int unsigned VW = $clog2(VERIFY_WORDS + 1);
    localparam int unsigned CW = $clog2(VERIFY_COMMAS + 1);
    localparam int unsigned WW = $clog2(ERR_WINDOW);
    localparam int unsigned EW = $clog2(ERR_THRESH + 1);

    localparam logic [HW-1:0] HUNT_LAST   = HW'(HUNT_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SLIP_SETTLE - 1);
    localparam logic [VW-1:0] VW_LAST     = VW'(VERIFY_WORDS - 1);
    localparam logic [CW-1:0] VC_MAX      = CW'(VERIFY_COMMAS);
    localparam logic [WW-1:0] WIN_LAST    = WW'(ERR_WINDOW - 1);
    localparam logic [EW-1:0] ERR_MAX     = EW'(ERR_THRESH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HUNT   = 3'd1,
        S_SLIP   = 3'd2,
        S_VERIFY = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    state_t cur, nxt;

    logic          err, comma;
    logic [HW-1:0] hunt_cnt;
    logic [SW-1:0] settle_cnt;
    logic [VW-1:0] vw_cnt;
    logic [CW-1:0] vc_cnt, vc_next;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err, win_err_new;
    logic [3:0]    sweep_cnt;
    logic          slip_start, verify_start;
    logic          bitslip_nxt, disp_load_nxt, disp_val_nxt;

    assign err   = word_valid & (code_err | disp_err);
    assign comma = word_valid & comma_det & ~code_err;
    assign state = cur;

    // Commas seen in VERIFY including the current word (saturating).
    // Window error count including the current word; the first word of each
    // window restarts the count, so an error there counts as 1.
    always_comb begin
        vc_next = vc_cnt;
        if (comma && vc_cnt != VC_MAX)
            vc_next = vc_cnt + 1'b1;
        win_err_new = win_err;
        if (word_valid) begin
            if (win_cnt == '0)
                win_err_new = err ? EW'(1) : '0;
            else if (err && win_err != ERR_MAX)
                win_err_new = win_err + 1'b1;
        end
    end

    // State register
    always_ff @(posedge byteclk) begin
        if (!rst_n)
            cur <= S_IDLE;
        else
            cur <= nxt;
    end

    // Next-state logic
    always_comb begin
        nxt = cur;
        if (!enable) begin
            nxt = S_IDLE;
        end else begin
            case (cur)
                S_IDLE:   nxt = S_HUNT;
                S_HUNT: begin
                    if (comma)
                        nxt = S_VERIFY;
                    else if (word_valid && hunt_cnt == HUNT_LAST)
                        nxt = S_SLIP;
                end
                S_SLIP: begin
                    if (settle_cnt == SETTLE_LAST)
                        nxt = S_HUNT;
                end
                S_VERIFY: begin
                    if (err)
                        nxt = S_SLIP;
                    else if (word_valid && vw_cnt == VW_LAST)
                        nxt = (vc_next == VC_MAX) ? S_LOCKED : S_HUNT;
                end
                S_LOCKED: begin
                    if (err && win_err_new == ERR_MAX)
                        nxt = S_HUNT;
                end
                default:  nxt = S_IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered pulse outputs
    always_comb begin
        slip_start    = (nxt == S_SLIP) && (cur != S_SLIP);
        verify_start  = (nxt == S_VERIFY) && (cur != S_VERIFY);
        bitslip_nxt   = slip_start;
        disp_load_nxt = 1'b0;
        disp_val_nxt  = disp_val;
        if (enable && (verify_start || (cur == S_LOCKED && comma))) begin
            disp_load_nxt = 1'b1;
            disp_val_nxt  = comma_pos;
        end
    end

    // Registered outputs and counters. Each per-state counter is cleared
    // whenever the FSM is not staying in its state, which covers entry.
    always_ff @(posedge byteclk) begin
        if (!rst_n) begin
            bitslip    <= 1'b0;
            disp_load  <= 1'b0;
            disp_val   <= 1'b0;
            link_up    <= 1'b0;
            align_fail <= 1'b0;
            slip_pos   <= '0;
            sweep_cnt  <= '0;
            hunt_cnt   <= '0;
            settle_cnt <= '0;
            vw_cnt     <= '0;
            vc_cnt     <= '0;
            win_cnt    <= '0;
            win_err    <= '0;
        end else begin
            bitslip   <= bitslip_nxt;
            disp_load <= disp_load_nxt;
            disp_val  <= disp_val_nxt;
            link_up   <= enable && (cur == S_LOCKED);

            if (slip_start) begin
                slip_pos <= (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
                if (sweep_cnt == 4'd9)
                    align_fail <= 1'b1;
                if (sweep_cnt != 4'd10)
                    sweep_cnt <= sweep_cnt + 4'd1;
            end
            if (verify_start)
                sweep_cnt <= '0;
            if (!enable) begin
                align_fail <= 1'b0;
                sweep_cnt  <= '0;
            end

            if (cur == S_HUNT && nxt == S_HUNT) begin
                if (word_valid && hunt_cnt != HUNT_LAST)
                    hunt_cnt <= hunt_cnt + 1'b1;
            end else begin
                hunt_cnt <= '0;
            end

            if (cur == S_SLIP && nxt == S_SLIP) begin
                if (settle_cnt != SETTLE_LAST)
                    settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end

            if (cur == S_VERIFY && nxt == S_VERIFY) begin
                if (word_valid) begin
                    if (vw_cnt != VW_LAST)
                        vw_cnt <= vw_cnt + 1'b1;
                    vc_cnt <= vc_next;
                end
            end else begin
                vw_cnt <= '0;
                vc_cnt <= '0;
            end

            if (cur == S_LOCKED && nxt == S_LOCKED) begin
                if (word_valid) begin
                    win_cnt <= (win_cnt == WIN_LAST) ? '0 : win_cnt + 1'b1;
                    win_err <= win_err_new;
                end
            end else begin
                win_cnt <= '0;
                win_err <= '0;
            end
        end
    end

`ifdef LINK_ALIGN_STATS_EN
    always_ff @(posedge byteclk) begin
        if (!rst_n || !enable) begin
            err_cnt    <= '0;
            relock_cnt <= '0;
        end else begin
            if (cur == S_LOCKED && err && err_cnt != '1)
                err_cnt <= err_cnt + 16'd1;
            if (cur == S_LOCKED && nxt == S_HUNT && relock_cnt != '1)
                relock_cnt <= relock_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_link_align_ctrl.sv
// tb_link_align_ctrl: self-checking bench for link_align_ctrl.
// Directed vector table, hand-written multi-cycle sequences, and randomized
// traffic compared against a behavioural reference model.
// Optional-feature ports are connected and checked when LINK_ALIGN_STATS_EN
// is defined.

module tb_link_align_ctrl;

    localparam int HUNT_TIMEOUT  = 32;
    localparam int SLIP_SETTLE   = 3;
    localparam int VERIFY_WORDS  = 16;
    localparam int VERIFY_COMMAS = 2;
    localparam int ERR_WINDOW    = 64;
    localparam int ERR_THRESH    = 4;

    localparam int ST_IDLE   = 0;
    localparam int ST_HUNT   = 1;
    localparam int ST_SLIP   = 2;
    localparam int ST_VERIFY = 3;
    localparam int ST_LOCKED = 4;

    logic       byteclk = 1'b0;
    logic       rst_n, enable, word_valid, comma_det, comma_pos, code_err, disp_err;
    logic       bitslip, disp_load, disp_val, link_up, align_fail;
    logic [3:0] slip_pos;
    logic [2:0] state;
`ifdef LINK_ALIGN_STATS_EN
    logic [15:0] err_cnt;
    logic [7:0]  relock_cnt;
`endif

    link_align_ctrl #(
        .HUNT_TIMEOUT (HUNT_TIMEOUT),
        .SLIP_SETTLE  (SLIP_SETTLE),
        .VERIFY_WORDS (VERIFY_WORDS),
        .VERIFY_COMMAS(VERIFY_COMMAS),
        .ERR_WINDOW   (ERR_WINDOW),
        .ERR_THRESH   (ERR_THRESH)
    ) dut (
        .byteclk   (byteclk),
        .rst_n     (rst_n),
        .enable    (enable),
        .word_valid(word_valid),
        .comma_det (comma_det),
        .comma_pos (comma_pos),
        .code_err  (code_err),
        .disp_err  (disp_err),
        .bitslip   (bitslip),
        .slip_pos  (slip_pos),
        .disp_load (disp_load),
        .disp_val  (disp_val),
        .link_up   (link_up),
        .state     (state),
        .align_fail(align_fail)
`ifdef LINK_ALIGN_STATS_EN
        ,
        .err_cnt   (err_cnt),
        .relock_cnt(relock_cnt)
`endif
    );

    always #5 byteclk = ~byteclk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks the link through the rules directly: words seen per phase,
    // slips since the last VERIFY entry, and a running word index since
    // lock whose quotient by ERR_WINDOW selects the error window.
    int m_state, m_slip_pos, m_hunt_words, m_settle, m_ver_words, m_ver_commas;
    int m_lock_idx, m_win_errs, m_slips, m_err_total, m_relocks;
    bit m_bitslip, m_disp_load, m_disp_val, m_link_up, m_align_fail;

    task automatic model_reset();
        m_state = ST_IDLE; m_slip_pos = 0; m_hunt_words = 0; m_settle = 0;
        m_ver_words = 0; m_ver_commas = 0; m_lock_idx = 0; m_win_errs = 0;
        m_slips = 0; m_err_total = 0; m_relocks = 0;
        m_bitslip = 0; m_disp_load = 0; m_disp_val = 0; m_link_up = 0; m_align_fail = 0;
    endtask

    task automatic model_slip();
        m_settle   = 0;
        m_bitslip  = 1;
        m_slip_pos = (m_slip_pos + 1) % 10;
        m_slips++;
        if (m_slips >= 10) m_align_fail = 1;
    endtask

    task automatic model_step(input bit en, wv, cd, cp, ce, de);
        bit e, c;
        int ns;
        e  = wv && (ce || de);
        c  = wv && cd && !ce;
        ns = m_state;
        m_link_up   = en && (m_state == ST_LOCKED);
        m_bitslip   = 0;
        m_disp_load = 0;
        if (!en) begin
            ns = ST_IDLE; m_align_fail = 0; m_slips = 0; m_err_total = 0; m_relocks = 0;
        end else begin
            case (m_state)
                ST_IDLE: begin ns = ST_HUNT; m_hunt_words = 0; end
                ST_HUNT: begin
                    if (c) begin
                        ns = ST_VERIFY; m_disp_load = 1; m_disp_val = cp;
                        m_ver_words = 0; m_ver_commas = 0; m_slips = 0;
                    end else if (wv) begin
                        m_hunt_words++;
                        if (m_hunt_words == HUNT_TIMEOUT) begin ns = ST_SLIP; model_slip(); end
                    end
                end
                ST_SLIP: begin
                    m_settle++;
                    if (m_settle == SLIP_SETTLE) begin ns = ST_HUNT; m_hunt_words = 0; end
                end
                ST_VERIFY: begin
                    if (e) begin
                        ns = ST_SLIP; model_slip();
                    end else if (wv) begin
                        m_ver_words++;
                        if (c) m_ver_commas++;
                        if (m_ver_words == VERIFY_WORDS) begin
                            if (m_ver_commas >= VERIFY_COMMAS) begin
                                ns = ST_LOCKED; m_lock_idx = 0; m_win_errs = 0;
                            end else begin
                                ns = ST_HUNT; m_hunt_words = 0;
                            end
                        end
                    end
                end
                ST_LOCKED: begin
                    if (c) begin m_disp_load = 1; m_disp_val = cp; end
                    if (wv) begin
                        if (m_lock_idx % ERR_WINDOW == 0) m_win_errs = 0;
                        m_lock_idx++;
                        if (e) begin
                            m_win_errs++;
                            if (m_err_total < 65535) m_err_total++;
                        end
                        if (m_win_errs >= ERR_THRESH) begin
                            ns = ST_HUNT; m_hunt_words = 0;
                            if (m_relocks < 255) m_relocks++;
                        end
                    end
                end
                default: ns = ST_IDLE;
            endcase
        end
        m_state = ns;
    endtask

    task automatic check_model();
        chk("state",      state,      m_state);
        chk("bitslip",    bitslip,    m_bitslip);
        chk("slip_pos",   slip_pos,   m_slip_pos);
        chk("disp_load",  disp_load,  m_disp_load);
        chk("disp_val",   disp_val,   m_disp_val);
        chk("link_up",    link_up,    m_link_up);
        chk("align_fail", align_fail, m_align_fail);
`ifdef LINK_ALIGN_STATS_EN
        chk("err_cnt",    err_cnt,    m_err_total);
        chk("relock_cnt", relock_cnt, m_relocks);
`endif
    endtask

    // One clock: drive inputs, model the edge, sample 1 time unit later.
    task automatic step(input bit en, wv, cd, cp, ce, de);
        enable = en; word_valid = wv; comma_det = cd; comma_pos = cp;
        code_err = ce; disp_err = de;
        @(posedge byteclk);
        model_step(en, wv, cd, cp, ce, de);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 0; enable = 1; word_valid = 1; comma_det = 1; comma_pos = 1;
        code_err = 0; disp_err = 0;
        repeat (2) @(posedge byteclk);
        #1;
        model_reset();
        chk("rst_state",      state,      0);
        chk("rst_bitslip",    bitslip,    0);
        chk("rst_slip_pos",   slip_pos,   0);
        chk("rst_disp_load",  disp_load,  0);
        chk("rst_disp_val",   disp_val,   0);
        chk("rst_link_up",    link_up,    0);
        chk("rst_align_fail", align_fail, 0);
        rst_n = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit en, wv, cd, cp, ce, de;
        int st;
        bit bs, dl, dv, lu;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit wv, bit cd, bit cp, int st, bit dl, bit dv, bit lu);
        vec_t v;
        v.en = 1; v.wv = wv; v.cd = cd; v.cp = cp; v.ce = 0; v.de = 0;
        v.st = st; v.bs = 0; v.dl = dl; v.dv = dv; v.lu = lu;
        return v;
    endfunction

    int slips_seen;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // IDLE -> HUNT, four plain words, comma (pos=1) on the fifth HUNT word,
        // 16 clean VERIFY words with commas on words 3 and 10, then LOCKED.
        tbl.push_back(mk(1, 0, 0, ST_HUNT, 0, 0, 0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 0, 0, ST_HUNT, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, ST_VERIFY, 1, 1, 0));
        for (int v = 1; v <= VERIFY_WORDS; v++)
            tbl.push_back(mk(1, (v == 3 || v == 10), 0,
                             (v == VERIFY_WORDS) ? ST_LOCKED : ST_VERIFY, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, ST_LOCKED, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, ST_LOCKED, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, ST_LOCKED, 0, 0, 1));

        do_reset();
        foreach (tbl[k]) begin
            step(tbl[k].en, tbl[k].wv, tbl[k].cd, tbl[k].cp, tbl[k].ce, tbl[k].de);
            chk("tbl_state",     state,     tbl[k].st);
            chk("tbl_bitslip",   bitslip,   tbl[k].bs);
            chk("tbl_disp_load", disp_load, tbl[k].dl);
            chk("tbl_disp_val",  disp_val,  tbl[k].dv);
            chk("tbl_link_up",   link_up,   tbl[k].lu);
        end

        // Hunt timeout: 32 comma-free words -> one slip, inputs ignored 3 cycles.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i < HUNT_TIMEOUT; i++) step(1, 1, 0, 0, 0, 0);
        chk("hto_pre_state", state, ST_HUNT);
        step(1, 1, 0, 0, 0, 0);
        chk("hto_state",    state,    ST_SLIP);
        chk("hto_bitslip",  bitslip,  1);
        chk("hto_slip_pos", slip_pos, 1);
        step(1, 1, 1, 1, 0, 0);
        chk("settle1_state", state, ST_SLIP);
        chk("settle1_bs",    bitslip, 0);
        step(1, 1, 1, 1, 0, 0);
        chk("settle2_state", state, ST_SLIP);
        step(1, 1, 1, 1, 0, 0);
        chk("settle3_state", state, ST_HUNT);
        chk("settle3_dl",    disp_load, 0);

        // No commas ever: ten slips wrap slip_pos and set align_fail.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        slips_seen = 0;
        for (int i = 0; i < 600 && slips_seen < 10; i++) begin
            step(1, 1, 0, 0, 0, 0);
            if (bitslip) begin
                slips_seen++;
                if (slips_seen == 9) chk("sweep9_align_fail", align_fail, 0);
            end
        end
        chk("sweep_count",      slips_seen, 10);
        chk("sweep_slip_pos",   slip_pos,   0);
        chk("sweep_align_fail", align_fail, 1);
        slips_seen = 0;
        for (int i = 0; i < 100 && slips_seen < 1; i++) begin
            step(1, 1, 0, 0, 0, 0);
            if (bitslip) slips_seen++;
        end
        chk("sweep11_seen",       slips_seen, 1);
        chk("sweep11_slip_pos",   slip_pos,   1);
        chk("sweep11_align_fail", align_fail, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("dis_state",      state,      ST_IDLE);
        chk("dis_align_fail", align_fail, 0);
        chk("dis_slip_pos",   slip_pos,   1);

        // VERIFY error on word 7 -> SLIP.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        chk("ver_entry_state", state,    ST_VERIFY);
        chk("ver_entry_dval",  disp_val, 0);
        for (int i = 1; i <= 6; i++) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("ver_err_state",   state,    ST_SLIP);
        chk("ver_err_bitslip", bitslip,  1);
        chk("ver_err_link",    link_up,  0);
        chk("ver_err_pos",     slip_pos, 1);

        // LOCKED error windows: 3 errors in window 1, 3 in window 2 (first one
        // on the window's first word), then a 4th in window 2 drops the link.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        for (int v = 1; v <= VERIFY_WORDS; v++) step(1, 1, (v <= 2), 0, 0, 0);
        chk("lock_state", state, ST_LOCKED);
        for (int i = 0; i <= 90; i++) begin
            bit e;
            e = (i == 10 || i == 20 || i == 30 || i == 64 || i == 80 || i == 90);
            step(1, 1, 0, 0, e, (i == 70));
            if (i < 90) begin
                if (i == 63 || i == 89) begin
                    chk("win_state", state,   ST_LOCKED);
                    chk("win_link",  link_up, 1);
                end
            end
        end
        chk("drop_state", state,   ST_HUNT);
        chk("drop_link0", link_up, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("drop_link1", link_up, 0);

        // Comma with code error is rejected in HUNT; with only a disparity
        // error it is still a comma.
        do_reset();
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 0);
        chk("bad_comma_state", state,     ST_HUNT);
        chk("bad_comma_dl",    disp_load, 0);
        step(1, 1, 1, 1, 0, 1);
        chk("dcomma_state", state,     ST_VERIFY);
        chk("dcomma_dl",    disp_load, 1);

        // Randomized traffic in phases with differing comma/error densities.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            int comma_pct, err_pct;
            comma_pct = (p == 0) ? 20 : (p == 1) ? 0 : (p == 2) ? 8 : 30;
            err_pct   = (p == 0) ? 1  : (p == 1) ? 0 : (p == 2) ? 6 : 2;
            for (int i = 0; i < 2000; i++) begin
                bit en, wv, cd, cp, ce, de;
                en = ($urandom_range(999) != 0);
                wv = ($urandom_range(99) < 80);
                cd = ($urandom_range(99) < comma_pct);
                cp = 1'($urandom_range(1));
                ce = ($urandom_range(99) < err_pct);
                de = ($urandom_range(99) < err_pct);
                step(en, wv, cd, cp, ce, de);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/link_align_ctrl.md
Name: link_align_ctrl

Overview:
- Word-alignment and link-state controller for the 8b/10b receive path. Runs on the byte clock.
- Watches the per-word comma and decoder-error flags coming back from the deserializer/decoder pair.
- Steps the deserializer word boundary with single-cycle bitslip pulses until commas are seen cleanly, then seeds the decoder running disparity and declares link up.
- While locked, it monitors the error rate and drops the link when the rate exceeds a threshold.

Parameters:
- HUNT_TIMEOUT, 32: valid words to wait for a comma before issuing a bitslip.
- SLIP_SETTLE, 3: byteclk cycles to ignore input after each bitslip.
- VERIFY_WORDS, 16: consecutive error-free valid words required in VERIFY.
- VERIFY_COMMAS, 2: commas required within VERIFY.
- ERR_WINDOW, 64: valid-word window length for error counting in LOCKED.
- ERR_THRESH, 4: errors within one window that cause link drop.

Ports:
- byteclk  in  1  byte clock; all logic on posedge.
- rst_n  in  1  synchronous reset, active low.
- enable  in  1  0 forces IDLE and clears align_fail.
- word_valid  in  1  a new 10-bit word and its flags are valid this cycle.
- comma_det  in  1  word equals either comma (1001111100 or 0110000011).
- comma_pos  in  1  qualifies comma_det: 1 = 1001111100, 0 = 0110000011.
- code_err  in  1  decoder code error for this word.
- disp_err  in  1  decoder disparity error for this word.
- bitslip  out  1  one-cycle pulse: shift deserializer boundary by one bit.
- slip_pos  out  4  current boundary offset, 0..9.
- disp_load  out  1  one-cycle pulse: load disp_val into decoder running disparity.
- disp_val  out  1  disparity value to load.
- link_up  out  1  registered; high only in LOCKED.
- state  out  3  0 IDLE, 1 HUNT, 2 SLIP, 3 VERIFY, 4 LOCKED.
- align_fail  out  1  sticky: a full 10-position sweep found no comma.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE. bitslip, disp_load, disp_val, link_up and align_fail = 0. slip_pos=0. All counters 0.
- err = word_valid & (code_err | disp_err). comma = word_valid & comma_det & ~code_err. A comma carrying a code error is not a comma.
- enable=0 in any state: next state IDLE. link_up=0 the next cycle. align_fail cleared. slip_pos held.
- IDLE -> HUNT when enable=1. Hunt counter cleared.
- HUNT:
  - comma: -> VERIFY. disp_load pulses the same cycle the state register updates. disp_val = comma_pos.
  - else count valid words. When the count reaches HUNT_TIMEOUT -> SLIP.
- SLIP:
  - bitslip=1 for exactly the first cycle in SLIP.
  - slip_pos increments mod 10 (9 -> 0).
  - Stays SLIP_SETTLE cycles ignoring all inputs, then -> HUNT with counters cleared.
  - 10 consecutive slips without entering VERIFY: set align_fail and keep sweeping. align_fail stays set until enable=0 or reset.
- VERIFY:
  - Counts valid words and commas.
  - Any err -> SLIP. A mis-framed comma is the assumed cause.
  - VERIFY_WORDS error-free words with at least VERIFY_COMMAS commas -> LOCKED. The slip-sweep counter is cleared.
  - VERIFY_WORDS reached with fewer commas -> HUNT, no slip.
- LOCKED:
  - link_up=1 from the cycle after entry.
  - Window counter counts valid words 0..ERR_WINDOW-1. Error counter counts err.
  - On window wrap the error count restarts. An err on the wrap word counts as 1 in the new window.
  - Error count reaching ERR_THRESH -> HUNT. No slip. link_up=0 the next cycle.
  - Each comma in LOCKED pulses disp_load with disp_val=comma_pos, which re-seeds the decoder disparity.
- word_valid=0 cycles advance no counters except the SLIP settle counter.
- Bitslip pulses are always separated by at least SLIP_SETTLE+1 cycles.
- Counters are sized by clog2 of their parameter and saturate rather than wrap.

Optional Feature:
- LINK_ALIGN_STATS_EN defined: adds err_cnt (out 16) and relock_cnt (out 8) after align_fail.
  - err_cnt: saturating count of err while LOCKED.
  - relock_cnt: saturating count of LOCKED -> HUNT transitions.
  - Both clear on reset or enable=0.
- Macro absent: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, enable=1, word_valid=1, comma at word 5 with comma_pos=1:
  - state reaches HUNT, then VERIFY on word 5 with disp_load=1 and disp_val=1.
  - With 16 clean words and 2 commas, link_up=1 one cycle after LOCKED entry.
- No commas for 32 valid words:
  - exactly one bitslip pulse and slip_pos=1.
  - Input ignored for 3 cycles, then state=HUNT.
- No commas ever:
  - after 10 slips, slip_pos wraps to 0 and align_fail=1.
  - enable=0 clears align_fail and sets state=IDLE.
- In VERIFY, code_err on word 7: -> SLIP, bitslip pulse, link_up stays 0.
- In LOCKED, inject 3 errors in window 1 and 3 more after the wrap: link stays up.
  - Then inject a 4th error in window 2: HUNT, and link_up falls the next cycle.
- Comma with code_err=1 while in HUNT: not accepted. State remains HUNT and disp_load=0.
